// File: rtl/store_size_unit_pkg.sv
// rtl/store_size_unit_pkg.sv - store-type codes, FSM states and alignment check for the store size unit
package store_size_unit_pkg;

  localparam logic [1:0] ST_SW = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SB = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_MERGE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Reserved type and any offset that does not fit the access width are rejected.
  function automatic logic is_misaligned(input logic [1:0] st, input logic [1:0] off);
    case (st)
      ST_SW:   return off != 2'b00;
      ST_SH:   return off[0];
      ST_SB:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - places the B byte/halfword into its little-endian lane of the memory word
module store_lane_merge
  import store_size_unit_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [31:0] b_data,
  input  logic [1:0]  store_type,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  always_comb begin
    merged = mem_word;
    case (store_type)
      ST_SW: merged = b_data;
      ST_SH: begin
        if (offset[1]) merged[31:16] = b_data[15:0];
        else           merged[15:0]  = b_data[15:0];
      end
      ST_SB:   merged[{offset, 3'b000} +: 8] = b_data[7:0];
      default: merged = mem_word;
    endcase
  end

endmodule

// File: rtl/store_size_unit.sv
// rtl/store_size_unit.sv - read-modify-write sequencer producing the memory write word for sw/sh/sb
module store_size_unit
  import store_size_unit_pkg::*;
#(
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_low,
  input  logic [31:0] reg_b_data,
  output logic        mem_rd_req,
  input  logic [31:0] mem_data_in,
  output logic [31:0] store_size_data,
  output logic        busy,
  output logic        done,
  output logic        align_err
);

  localparam int             CNT_W = $clog2(MEM_RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_RD_LATENCY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_next;
  logic [1:0]       st_q, off_q;
  logic [31:0]      b_q, mem_q, merged;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  store_lane_merge u_merge (
    .mem_word   (mem_q),
    .b_data     (b_q),
    .store_type (st_q),
    .offset     (off_q),
    .merged     (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      st_q            <= '0;
      off_q           <= '0;
      b_q             <= '0;
      mem_q           <= '0;
      err_q           <= 1'b0;
      cnt_q           <= '0;
      store_size_data <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            st_q  <= store_type;
            off_q <= addr_low;
            b_q   <= reg_b_data;
            err_q <= is_misaligned(store_type, addr_low);
          end
        end
        S_READ: cnt_q <= LAT;
        S_WAIT: begin
          cnt_q <= cnt_q - ONE;
          // Only the last WAIT cycle carries valid read data.
          if (cnt_q == ONE) mem_q <= mem_data_in;
        end
        S_MERGE: store_size_data <= merged;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    mem_rd_req = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    align_err  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (is_misaligned(store_type, addr_low)) state_next = S_DONE;
          else if (store_type == ST_SW)            state_next = S_MERGE;
          else                                     state_next = S_READ;
        end
      end
      S_READ: begin
        mem_rd_req = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == ONE) state_next = S_MERGE;
      end
      S_MERGE: state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        align_err  = err_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_size_unit.sv
// tb/tb_store_size_unit.sv - directed self-checking bench for store_size_unit at read latencies 1 and 3
module tb_store_size_unit;

  localparam int NCYC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start3;
  logic [1:0]  store_type, addr_low;
  logic [31:0] reg_b_data, mem_data_in;
  logic        rd1, busy1, done1, err1, rd3, busy3, done3, err3;
  logic [31:0] data1, data3;

  int tests = 0;
  int failed = 0;

  logic [15:0] rd_mask, done_mask, err_mask, busy_mask;
  logic [31:0] rec_data [NCYC];

  always #5 clk = ~clk;

  store_size_unit #(.MEM_RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .store_type(store_type),
    .addr_low(addr_low), .reg_b_data(reg_b_data), .mem_rd_req(rd1),
    .mem_data_in(mem_data_in), .store_size_data(data1), .busy(busy1),
    .done(done1), .align_err(err1)
  );

  store_size_unit #(.MEM_RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .store_type(store_type),
    .addr_low(addr_low), .reg_b_data(reg_b_data), .mem_rd_req(rd3),
    .mem_data_in(mem_data_in), .store_size_data(data3), .busy(busy3),
    .done(done3), .align_err(err3)
  );

  // Cycle 0 is the start cycle; outputs are recorded at the falling edge of cycles 1..NCYC-1.
  // Inputs other than the final-WAIT memory word are garbage after cycle 0.
  task automatic run_op(input bit use3, input logic [1:0] st, input logic [1:0] al,
                        input logic [31:0] b, input logic [31:0] mem, input int repulse);
    int lat;
    lat = use3 ? 3 : 1;
    rd_mask = '0; done_mask = '0; err_mask = '0; busy_mask = '0;
    for (int i = 0; i < NCYC; i++) rec_data[i] = 'x;
    store_type = st; addr_low = al; reg_b_data = b; mem_data_in = 32'h5A5A5A5A;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    for (int c = 1; c < NCYC; c++) begin
      @(negedge clk);
      rd_mask[c]   = use3 ? rd3 : rd1;
      done_mask[c] = use3 ? done3 : done1;
      err_mask[c]  = use3 ? err3 : err1;
      busy_mask[c] = use3 ? busy3 : busy1;
      rec_data[c]  = use3 ? data3 : data1;
      start1 = 1'b0; start3 = 1'b0;
      if (c == repulse) begin
        if (use3) start3 = 1'b1; else start1 = 1'b1;
      end
      store_type  = 2'b11;
      addr_low    = al ^ 2'b01;
      reg_b_data  = 32'h0BAD0000 | c;
      mem_data_in = (c == 1 + lat) ? mem : (32'h5A5A5A5A ^ c);
    end
    start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0;
    store_type = '0; addr_low = '0; reg_b_data = '0; mem_data_in = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({rd1, busy1, done1, err1, rd3, busy3, done3, err3} !== 8'b0) begin
      failed++; $display("FAIL reset_flags got %b want 00000000", {rd1, busy1, done1, err1, rd3, busy3, done3, err3});
    end
    tests++;
    if (data1 !== 32'h0 || data3 !== 32'h0) begin
      failed++; $display("FAIL reset_data got %h/%h want 0", data1, data3);
    end
    reset = 1'b0;
  endtask

  task automatic test_sb_lat1();
    run_op(1'b0, 2'b10, 2'd2, 32'h000000EE, 32'hAABBCCDD, -1);
    tests++;
    if (rd_mask !== 16'h0002) begin failed++; $display("FAIL sb_rd_mask got %h want 0002", rd_mask); end
    tests++;
    if (done_mask !== 16'h0010) begin failed++; $display("FAIL sb_done_mask got %h want 0010", done_mask); end
    tests++;
    if (rec_data[4] !== 32'hAAEECCDD) begin failed++; $display("FAIL sb_data got %h want aaeeccdd", rec_data[4]); end
    tests++;
    if (err_mask !== 16'h0) begin failed++; $display("FAIL sb_err got %h want 0000", err_mask); end
  endtask

  task automatic test_sh_sb_lanes();
    logic [1:0]  t_st  [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
    logic [1:0]  t_al  [5] = '{2'd0, 2'd2, 2'd0, 2'd1, 2'd3};
    logic [31:0] t_b   [5] = '{32'hFFFF5566, 32'hFFFF5566, 32'h00000099, 32'h00000099, 32'h00000099};
    logic [31:0] t_exp [5] = '{32'h11225566, 32'h55663344, 32'h11223399, 32'h11229944, 32'h99223344};
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, t_st[i], t_al[i], t_b[i], 32'h11223344, -1);
      tests++;
      if (rec_data[4] !== t_exp[i] || rec_data[6] !== t_exp[i]) begin
        failed++; $display("FAIL lane_%0d got %h/%h want %h", i, rec_data[4], rec_data[6], t_exp[i]);
      end
      tests++;
      if (done_mask !== 16'h0010) begin failed++; $display("FAIL lane_%0d_done got %h want 0010", i, done_mask); end
    end
  endtask

  task automatic test_sw();
    run_op(1'b0, 2'b00, 2'd0, 32'hDEADBEEF, 32'h11111111, -1);
    tests++;
    if (rd_mask !== 16'h0) begin failed++; $display("FAIL sw_rd_mask got %h want 0000", rd_mask); end
    tests++;
    if (done_mask !== 16'h0004) begin failed++; $display("FAIL sw_done_mask got %h want 0004", done_mask); end
    tests++;
    if (busy_mask !== 16'h0006) begin failed++; $display("FAIL sw_busy_mask got %h want 0006", busy_mask); end
    tests++;
    if (rec_data[2] !== 32'hDEADBEEF) begin failed++; $display("FAIL sw_data got %h want deadbeef", rec_data[2]); end
  endtask

  task automatic test_align_err();
    logic [1:0] t_st [3] = '{2'b01, 2'b00, 2'b11};
    logic [1:0] t_al [3] = '{2'd1, 2'd3, 2'd0};
    for (int i = 0; i < 3; i++) begin
      run_op(1'b0, t_st[i], t_al[i], 32'h01020304, 32'h55555555, -1);
      tests++;
      if (done_mask !== 16'h0002 || err_mask !== 16'h0002) begin
        failed++; $display("FAIL err_%0d_pulse done %h err %h want 0002/0002", i, done_mask, err_mask);
      end
      tests++;
      if (rd_mask !== 16'h0 || busy_mask !== 16'h0002) begin
        failed++; $display("FAIL err_%0d_rd_busy rd %h busy %h want 0000/0002", i, rd_mask, busy_mask);
      end
      tests++;
      if (rec_data[1] !== 32'hDEADBEEF || rec_data[5] !== 32'hDEADBEEF) begin
        failed++; $display("FAIL err_%0d_data got %h/%h want deadbeef", i, rec_data[1], rec_data[5]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic saw_rd, saw_done;
    store_type = 2'b10; addr_low = 2'd1; reg_b_data = 32'h77; mem_data_in = 32'h0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    tests++;
    if (busy1 !== 1'b1 || rd1 !== 1'b0) begin
      failed++; $display("FAIL rst_mid_in_wait busy %b rd %b want 1/0", busy1, rd1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if ({rd1, busy1, done1, err1} !== 4'b0 || data1 !== 32'h0) begin
      failed++; $display("FAIL rst_mid_outputs flags %b data %h want 0000/0", {rd1, busy1, done1, err1}, data1);
    end
    saw_rd = 1'b0; saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      saw_rd   |= rd1;
      saw_done |= done1;
    end
    tests++;
    if (saw_rd !== 1'b0 || saw_done !== 1'b0) begin
      failed++; $display("FAIL rst_mid_quiet rd %b done %b want 0/0", saw_rd, saw_done);
    end
    run_op(1'b0, 2'b00, 2'd0, 32'h12345678, 32'h0, -1);
    tests++;
    if (rec_data[2] !== 32'h12345678 || done_mask !== 16'h0004) begin
      failed++; $display("FAIL rst_mid_sw got %h done %h want 12345678/0004", rec_data[2], done_mask);
    end
  endtask

  task automatic test_busy_lat3();
    run_op(1'b1, 2'b01, 2'd2, 32'h0000BEEF, 32'hCAFEF00D, 2);
    tests++;
    if (done_mask !== 16'h0040) begin failed++; $display("FAIL lat3_done_mask got %h want 0040", done_mask); end
    tests++;
    if (rd_mask !== 16'h0002 || err_mask !== 16'h0) begin
      failed++; $display("FAIL lat3_rd_err rd %h err %h want 0002/0000", rd_mask, err_mask);
    end
    tests++;
    if (busy_mask !== 16'h007E) begin failed++; $display("FAIL lat3_busy_mask got %h want 007e", busy_mask); end
    tests++;
    if (rec_data[6] !== 32'hBEEFF00D || rec_data[9] !== 32'hBEEFF00D) begin
      failed++; $display("FAIL lat3_data got %h/%h want beeff00d", rec_data[6], rec_data[9]);
    end
  endtask

  initial begin
    test_reset();
    test_sb_lat1();
    test_sh_sb_lanes();
    test_sw();
    test_align_err();
    test_reset_mid_op();
    test_busy_lat3();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
